// File: rtl/memory_cycle.sv
// memory_cycle: MEM stage of the 5-stage RISC-V pipeline.
// Word-addressed data memory plus the MEM/WB pipeline register.
// Optional build macro: DMEM_WRITE_FIRST_EN selects a write-first bypass
// for a load and a store to the same word in the same cycle; the default
// build is read-first.
module memory_cycle #(
  parameter int unsigned DMEM_DEPTH = 1024,
  parameter int unsigned DMEM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW
);

  // Storage starts zeroed and is deliberately never touched by reset.
  logic [31:0] mem [DMEM_DEPTH] = '{default: '0};

  logic [DMEM_AW-1:0] word_idx;
  logic [31:0]        read_data;

  // Byte address to word index: drop the byte offset, wrap above the depth.
  always_comb begin
    word_idx = ALU_ResultM[DMEM_AW+1:2];
  end

  // Combinational read every cycle; the store always targets the same word
  // the cycle reads, so the bypass only needs the store enable.
  always_comb begin
    read_data = mem[word_idx];
`ifdef DMEM_WRITE_FIRST_EN
    if (MemWriteM) begin
      read_data = WriteDataM;
    end
`endif
  end

  // Full-word store, suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst && MemWriteM) begin
      mem[word_idx] <= WriteDataM;
    end
  end

  // MEM/WB pipeline register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else begin
      RegWriteW   <= RegWriteM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= read_data;
    end
  end

endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: directed self-checking bench for memory_cycle.
module tb_memory_cycle;

  logic        clk;
  logic        rst;
  logic        RegWriteM;
  logic        MemWriteM;
  logic        ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M;
  logic [31:0] WriteDataM;
  logic [31:0] ALU_ResultM;
  logic        RegWriteW;
  logic        ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W;
  logic [31:0] ALU_ResultW;
  logic [31:0] ReadDataW;

  int n_checks = 0;
  int n_fail   = 0;

  memory_cycle #(
    .DMEM_DEPTH(1024),
    .DMEM_AW   (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RD_M       (RD_M),
    .PCPlus4M   (PCPlus4M),
    .WriteDataM (WriteDataM),
    .ALU_ResultM(ALU_ResultM),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RD_W       (RD_W),
    .PCPlus4W   (PCPlus4W),
    .ALU_ResultW(ALU_ResultW),
    .ReadDataW  (ReadDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle for sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Start in reset with busy inputs: outputs must be 0 across edges.
    rst = 1'b0;
    RegWriteM = 1'b1; ResultSrcM = 1'b0; MemWriteM = 1'b0;
    RD_M = 5'd1; PCPlus4M = 32'h4; ALU_ResultM = 32'h20; WriteDataM = 32'h0;
    #2;
    n_checks++;
    if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_initial: got %h expected 0",
               {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW});
    end
    step();
    n_checks++;
    if ({RegWriteW, RD_W, PCPlus4W, ALU_ResultW} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_held_edge: got %h expected 0", {RegWriteW, RD_W, PCPlus4W, ALU_ResultW});
    end
    // Release, capture, then pulse reset mid-cycle.
    rst = 1'b1;
    step();
    n_checks++;
    if ({RegWriteW, RD_W, PCPlus4W, ALU_ResultW} !== {1'b1, 5'd1, 32'h4, 32'h20}) begin
      n_fail++;
      $display("FAIL reset_release_capture: got %h expected %h",
               {RegWriteW, RD_W, PCPlus4W, ALU_ResultW}, {1'b1, 5'd1, 32'h4, 32'h20});
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !== 103'd0) begin
      n_fail++;
      $display("FAIL reset_async_clear: got %h expected 0",
               {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW});
    end
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if ({RegWriteW, RD_W, PCPlus4W, ALU_ResultW} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_hold_after_release: got %h expected 0", {RegWriteW, RD_W, PCPlus4W, ALU_ResultW});
    end
  endtask

  task automatic test_pass_through();
    RegWriteM = 1'b1; ResultSrcM = 1'b0; MemWriteM = 1'b0;
    RD_M = 5'd1; PCPlus4M = 32'h4; ALU_ResultM = 32'h20; WriteDataM = 32'hFFFF_FFFF;
    step();
    n_checks++;
    if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !==
        {1'b1, 1'b0, 5'd1, 32'h4, 32'h20, 32'h0}) begin
      n_fail++;
      $display("FAIL pass_through_a: got %h expected %h",
               {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW},
               {1'b1, 1'b0, 5'd1, 32'h4, 32'h20, 32'h0});
    end
    RegWriteM = 1'b0; ResultSrcM = 1'b1;
    RD_M = 5'd31; PCPlus4M = 32'hFFFF_FFFC; ALU_ResultM = 32'h0000_3FFC;
    step();
    n_checks++;
    if ({RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW} !==
        {1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0000_3FFC, 32'h0}) begin
      n_fail++;
      $display("FAIL pass_through_b: got %h expected %h",
               {RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW},
               {1'b0, 1'b1, 5'd31, 32'hFFFF_FFFC, 32'h0000_3FFC, 32'h0});
    end
  endtask

  task automatic test_store_load();
    logic [31:0] exp_same_edge;
`ifdef DMEM_WRITE_FIRST_EN
    exp_same_edge = 32'h10;
`else
    exp_same_edge = 32'h0;
`endif
    ResultSrcM = 1'b1; RegWriteM = 1'b1; RD_M = 5'd5;
    MemWriteM = 1'b1; ALU_ResultM = 32'h20; WriteDataM = 32'h10;
    step();
    n_checks++;
    if (ReadDataW !== exp_same_edge) begin
      n_fail++;
      $display("FAIL store_edge_read: got %h expected %h", ReadDataW, exp_same_edge);
    end
    MemWriteM = 1'b0; WriteDataM = 32'h0;
    step();
    n_checks++;
    if (ReadDataW !== 32'h10) begin
      n_fail++;
      $display("FAIL load_after_store: got %h expected %h", ReadDataW, 32'h10);
    end
  endtask

  task automatic test_wrap_align();
    MemWriteM = 1'b1; ALU_ResultM = 32'h0; WriteDataM = 32'hDEAD_BEEF;
    step();
    MemWriteM = 1'b0; ALU_ResultM = 32'h2;
    step();
    n_checks++;
    if (ReadDataW !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL align_addr2: got %h expected %h", ReadDataW, 32'hDEAD_BEEF);
    end
    ALU_ResultM = 32'h1000;
    step();
    n_checks++;
    if (ReadDataW !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL wrap_addr1000: got %h expected %h", ReadDataW, 32'hDEAD_BEEF);
    end
    ALU_ResultM = 32'h4;
    step();
    n_checks++;
    if (ReadDataW !== 32'h0) begin
      n_fail++;
      $display("FAIL neighbour_word: got %h expected %h", ReadDataW, 32'h0);
    end
    // Last word, reached through an aliased address above the depth.
    MemWriteM = 1'b1; ALU_ResultM = 32'hFFC; WriteDataM = 32'h1234_5678;
    step();
    MemWriteM = 1'b0; ALU_ResultM = 32'h1FFF;
    step();
    n_checks++;
    if (ReadDataW !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL wrap_last_word: got %h expected %h", ReadDataW, 32'h1234_5678);
    end
  endtask

  task automatic test_reset_retention();
    MemWriteM = 1'b1; ALU_ResultM = 32'h8; WriteDataM = 32'h55;
    step();
    ALU_ResultM = 32'h100; WriteDataM = 32'hAA;
    #2;
    rst = 1'b0;
    step();
    step();
    MemWriteM = 1'b0;
    rst = 1'b1;
    ALU_ResultM = 32'h8;
    step();
    n_checks++;
    if (ReadDataW !== 32'h55) begin
      n_fail++;
      $display("FAIL retain_across_reset: got %h expected %h", ReadDataW, 32'h55);
    end
    ALU_ResultM = 32'h100;
    step();
    n_checks++;
    if (ReadDataW !== 32'h0) begin
      n_fail++;
      $display("FAIL no_write_in_reset: got %h expected %h", ReadDataW, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_first;
    logic [31:0] exp_second;
`ifdef DMEM_WRITE_FIRST_EN
    exp_first  = 32'h77;
    exp_second = 32'h99;
`else
    exp_first  = 32'h0;
    exp_second = 32'h77;
`endif
    MemWriteM = 1'b1; ALU_ResultM = 32'h40; WriteDataM = 32'h77;
    step();
    n_checks++;
    if (ReadDataW !== exp_first) begin
      n_fail++;
      $display("FAIL b2b_first_store: got %h expected %h", ReadDataW, exp_first);
    end
    WriteDataM = 32'h99;
    step();
    n_checks++;
    if (ReadDataW !== exp_second) begin
      n_fail++;
      $display("FAIL b2b_second_store: got %h expected %h", ReadDataW, exp_second);
    end
    MemWriteM = 1'b0;
    step();
    n_checks++;
    if (ReadDataW !== 32'h99) begin
      n_fail++;
      $display("FAIL b2b_final_load: got %h expected %h", ReadDataW, 32'h99);
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_store_load();
    test_wrap_align();
    test_reset_retention();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_cycle.md
Name: memory_cycle

Overview:
- MEM stage of the 5-stage RISC-V pipeline core.
- Contains a word-addressed data memory and the MEM/WB pipeline register.
- Performs the load/store access using the address ALU_ResultM.
- Forwards control, destination register, PC+4, ALU result and read data to the writeback stage, one cycle later.

Parameters:
- DMEM_DEPTH, 1024, number of 32-bit words in data memory (power of two).
- DMEM_AW, 10, word-index width; must equal log2(DMEM_DEPTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- RegWriteM  input  1  register-file write enable from EX/MEM
- MemWriteM  input  1  data-memory store enable
- ResultSrcM  input  1  writeback select (0 = ALU result, 1 = load data); passed through only
- RD_M  input  5  destination register index
- PCPlus4M  input  32  PC+4 of the instruction
- WriteDataM  input  32  store data
- ALU_ResultM  input  32  byte address / ALU result
- RegWriteW  output  1  registered RegWriteM
- ResultSrcW  output  1  registered ResultSrcM
- RD_W  output  5  registered RD_M
- PCPlus4W  output  32  registered PCPlus4M
- ALU_ResultW  output  32  registered ALU_ResultM
- ReadDataW  output  32  registered data-memory read data

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low.
- Reset values: while rst=0, all outputs (RegWriteW, ResultSrcW, RD_W, PCPlus4W, ALU_ResultW, ReadDataW) are forced to 0 immediately, with no clock needed.
- Leaving reset: on rst rising, outputs hold 0 until the next rising clk edge.
- Pipeline register: on each rising clk edge with rst=1, every W output captures its M counterpart. Latency is exactly 1 cycle. There is no stall or flush input.
- Memory address: word index = ALU_ResultM[DMEM_AW+1:2]. Bits [1:0] are ignored, so accesses are word-aligned. Upper bits are ignored, so addresses wrap modulo DMEM_DEPTH words.
- Read: combinational read of mem[index]. The result is registered into ReadDataW at the rising edge. The read happens every cycle regardless of ResultSrcM or MemWriteM.
- Write: at a rising clk edge with rst=1 and MemWriteM=1, mem[index] <= WriteDataM (full 32-bit word).
- No writes occur while rst=0.
- Read during write to the same index in the same cycle: ReadDataW captures the OLD contents (read-first), unless DMEM_WRITE_FIRST_EN is defined.
- Memory contents: all words are 0 at time zero. Contents are NOT cleared by rst and are retained across reset.
- ResultSrcM and RegWriteM never affect memory; they are only delayed.
- Unknown/X on MemWriteM: no requirement beyond simulation X-propagation. The bench drives known values.

Optional Feature:
- Macro: DMEM_WRITE_FIRST_EN.
- Defined: when MemWriteM=1 and the store writes the same index the cycle reads, ReadDataW captures WriteDataM (write-first bypass).
- Undefined: read-first behaviour as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset:
  - Stimulus: drive RegWriteM=1, RD_M=1, PCPlus4M=0x4, ALU_ResultM=0x20, then pulse rst=0 mid-cycle.
  - Response: all outputs go 0 immediately, without a clock edge, and stay 0 until the first edge after rst=1.
- Pass-through:
  - Stimulus: rst=1, RegWriteM=1, ResultSrcM=0, RD_M=1, PCPlus4M=0x4, ALU_ResultM=0x20, MemWriteM=0.
  - Response: after one edge, RegWriteW=1, RD_W=1, PCPlus4W=0x4, ALU_ResultW=0x20, ReadDataW=0.
- Store then load:
  - Stimulus: MemWriteM=1, ALU_ResultM=0x20, WriteDataM=0x10 for one edge; then MemWriteM=0, same address.
  - Response: on the next edge ReadDataW=0x10.
  - Read-first build: the ReadDataW captured on the store edge itself is 0.
- Wrap and alignment:
  - Stimulus: store 0xDEADBEEF at address 0x0; then read address 0x2 and address 0x1000 (DMEM_DEPTH=1024).
  - Response: both reads return 0xDEADBEEF.
- Reset retention:
  - Stimulus: store 0x55 at 0x8, assert rst=0 for 2 cycles, release, then read 0x8.
  - Response: ReadDataW=0x55.
  - Stimulus: MemWriteM=1 held during reset with a different address.
  - Response: that word stays 0.
- Write-first build (DMEM_WRITE_FIRST_EN):
  - Stimulus: store 0x77 at 0x40.
  - Response: ReadDataW=0x77 on that same edge.
